// File: rtl/gen_mod_ctrl.sv
// Harmonic generator control: applies hp/phase writes on the next modulation-period
// trigger and runs stepped phase sweeps with a programmable dwell per step.
module gen_mod_ctrl #(
  parameter int PHASE_N = 2520,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               harmonic_trig,
  input  logic               cfg_wr,
  input  logic [13:0]        cfg_hp,
  input  logic [11:0]        cfg_phase,
  output logic               cfg_busy,
  input  logic               sweep_start,
  input  logic               sweep_abort,
  input  logic [11:0]        sweep_step,
  input  logic [11:0]        sweep_count,
  input  logic [DWELL_W-1:0] sweep_dwell,
  output logic [13:0]        hp,
  output logic [11:0]        phase,
  output logic               sweep_active,
  output logic               step_trig,
  output logic               sweep_done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_SWEEP = 2'd2
  } state_e;

  localparam logic [12:0] PN    = 13'(PHASE_N);
  localparam logic [11:0] PN_M1 = 12'(PHASE_N - 1);

  state_e             state_q, state_d;
  logic [13:0]        hp_q, hp_d, sh_hp_q, sh_hp_d;
  logic [11:0]        phase_q, phase_d, sh_phase_q, sh_phase_d;
  logic [11:0]        step_q, step_d, count_q, count_d, step_cnt_q, step_cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
  logic               cfg_busy_q, cfg_busy_d, sweep_active_q, sweep_active_d;
  logic               step_trig_q, step_trig_d, sweep_done_q, sweep_done_d;

  logic [11:0] cfg_phase_clamped, sweep_step_red, phase_next;
  logic [12:0] phase_sum;

  always_comb begin
    cfg_phase_clamped = ({1'b0, cfg_phase} >= PN) ? PN_M1 : cfg_phase;
    sweep_step_red    = ({1'b0, sweep_step} >= PN) ? 12'({1'b0, sweep_step} - PN) : sweep_step;
    phase_sum         = {1'b0, phase_q} + {1'b0, step_q};
    phase_next        = (phase_sum >= PN) ? 12'(phase_sum - PN) : phase_sum[11:0];
  end

  always_comb begin
    state_d      = state_q;
    hp_d         = hp_q;
    phase_d      = phase_q;
    sh_hp_d      = sh_hp_q;
    sh_phase_d   = sh_phase_q;
    step_d       = step_q;
    count_d      = count_q;
    dwell_d      = dwell_q;
    dwell_cnt_d  = dwell_cnt_q;
    step_cnt_d   = step_cnt_q;
    step_trig_d  = 1'b0;
    sweep_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // cfg_wr outranks sweep_start; a coincident trigger never applies a fresh write
        if (cfg_wr) begin
          sh_hp_d    = cfg_hp;
          sh_phase_d = cfg_phase_clamped;
          state_d    = S_PEND;
        end else if (sweep_start) begin
          step_d  = sweep_step_red;
          count_d = sweep_count;
          dwell_d = sweep_dwell;
          if (sweep_count == 12'd0) begin
            sweep_done_d = 1'b1;
          end else begin
            dwell_cnt_d = '0;
            step_cnt_d  = '0;
            state_d     = S_SWEEP;
          end
        end
      end
      S_PEND: begin
        if (sweep_abort) begin
          sh_hp_d    = '0;
          sh_phase_d = '0;
          state_d    = S_IDLE;
        end else if (cfg_wr) begin
          sh_hp_d    = cfg_hp;
          sh_phase_d = cfg_phase_clamped;
          if (harmonic_trig) begin
            hp_d    = cfg_hp;
            phase_d = cfg_phase_clamped;
            state_d = S_IDLE;
          end
        end else if (harmonic_trig) begin
          hp_d    = sh_hp_q;
          phase_d = sh_phase_q;
          state_d = S_IDLE;
        end
      end
      S_SWEEP: begin
        if (sweep_abort) begin
          sh_hp_d    = '0;
          sh_phase_d = '0;
          state_d    = S_IDLE;
        end else if (harmonic_trig) begin
          if (dwell_cnt_q == dwell_q) begin
            phase_d     = phase_next;
            step_trig_d = 1'b1;
            dwell_cnt_d = '0;
            step_cnt_d  = step_cnt_q + 12'd1;
            if (step_cnt_q == count_q - 12'd1) begin
              sweep_done_d = 1'b1;
              state_d      = S_IDLE;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    cfg_busy_d     = (state_d == S_PEND);
    sweep_active_d = (state_d == S_SWEEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      hp_q           <= '0;
      phase_q        <= '0;
      sh_hp_q        <= '0;
      sh_phase_q     <= '0;
      step_q         <= '0;
      count_q        <= '0;
      dwell_q        <= '0;
      dwell_cnt_q    <= '0;
      step_cnt_q     <= '0;
      cfg_busy_q     <= 1'b0;
      sweep_active_q <= 1'b0;
      step_trig_q    <= 1'b0;
      sweep_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      hp_q           <= hp_d;
      phase_q        <= phase_d;
      sh_hp_q        <= sh_hp_d;
      sh_phase_q     <= sh_phase_d;
      step_q         <= step_d;
      count_q        <= count_d;
      dwell_q        <= dwell_d;
      dwell_cnt_q    <= dwell_cnt_d;
      step_cnt_q     <= step_cnt_d;
      cfg_busy_q     <= cfg_busy_d;
      sweep_active_q <= sweep_active_d;
      step_trig_q    <= step_trig_d;
      sweep_done_q   <= sweep_done_d;
    end
  end

  assign hp           = hp_q;
  assign phase        = phase_q;
  assign cfg_busy     = cfg_busy_q;
  assign sweep_active = sweep_active_q;
  assign step_trig    = step_trig_q;
  assign sweep_done   = sweep_done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_gen_mod_ctrl.sv
// Directed bench for gen_mod_ctrl: stimulus pushes expected output events
// {hp, phase, step_trig, sweep_done}; a negedge monitor pops and compares them.
module tb_gen_mod_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        harmonic_trig = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [13:0] cfg_hp = '0;
  logic [11:0] cfg_phase = '0;
  logic        cfg_busy;
  logic        sweep_start = 1'b0;
  logic        sweep_abort = 1'b0;
  logic [11:0] sweep_step = '0;
  logic [11:0] sweep_count = '0;
  logic [15:0] sweep_dwell = '0;
  logic [13:0] hp;
  logic [11:0] phase;
  logic        sweep_active;
  logic        step_trig;
  logic        sweep_done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [27:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [13:0] prev_hp = '0;
  logic [11:0] prev_phase = '0;

  gen_mod_ctrl #(.PHASE_N(2520), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .harmonic_trig(harmonic_trig),
    .cfg_wr(cfg_wr), .cfg_hp(cfg_hp), .cfg_phase(cfg_phase), .cfg_busy(cfg_busy),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort), .sweep_step(sweep_step),
    .sweep_count(sweep_count), .sweep_dwell(sweep_dwell),
    .hp(hp), .phase(phase), .sweep_active(sweep_active),
    .step_trig(step_trig), .sweep_done(sweep_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (hp != prev_hp || phase != prev_phase || step_trig || sweep_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: act hp=%0d phase=%0d st=%0b done=%0b exp=none",
                   hp, phase, step_trig, sweep_done);
        end else begin
          logic [27:0] e;
          e = exp_q.pop_front();
          if ({hp, phase, step_trig, sweep_done} !== e) begin
            errors++;
            $display("FAIL event: act hp=%0d phase=%0d st=%0b done=%0b exp hp=%0d phase=%0d st=%0b done=%0b",
                     hp, phase, step_trig, sweep_done, e[27:14], e[13:2], e[1], e[0]);
          end
        end
      end
      prev_hp    = hp;
      prev_phase = phase;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] h, input logic [11:0] p, input logic st, input logic dn);
    exp_q.push_back({h, p, st, dn});
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [13:0] h, input logic [11:0] p, input logic trig);
    cfg_wr = 1'b1; cfg_hp = h; cfg_phase = p; harmonic_trig = trig;
    tick();
    cfg_wr = 1'b0; harmonic_trig = 1'b0;
  endtask

  task automatic do_trig(input logic abort);
    harmonic_trig = 1'b1; sweep_abort = abort;
    tick();
    harmonic_trig = 1'b0; sweep_abort = 1'b0;
  endtask

  task automatic do_sweep(input logic [11:0] st, input logic [11:0] cnt, input logic [15:0] dw);
    sweep_start = 1'b1; sweep_step = st; sweep_count = cnt; sweep_dwell = dw;
    tick();
    sweep_start = 1'b0;
  endtask

  logic [11:0] sweep_exp [4];
  int busy_cycles;

  initial begin
    sweep_exp[0] = 12'd1000; sweep_exp[1] = 12'd2000;
    sweep_exp[2] = 12'd480;  sweep_exp[3] = 12'd1480;

    // reset state
    repeat (3) tick();
    rst = 1'b0;
    check("rst_hp", int'(hp), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_busy", int'(cfg_busy), 0);
    check("rst_active", int'(sweep_active), 0);
    check("rst_pulses", int'({step_trig, sweep_done}), 0);
    mon_en = 1'b1;

    // write hp=99 phase=300, trigger 10 cycles later
    do_cfg(14'd99, 12'd300, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (cfg_busy) busy_cycles++;
      if (i < 9) tick();
    end
    check("busy_cycles", busy_cycles, 10);
    push(14'd99, 12'd300, 1'b0, 1'b0);
    do_trig(1'b0);
    check("busy_clear", int'(cfg_busy), 0);
    check("hp_99", int'(hp), 99);

    // phase clamp
    do_cfg(14'd5, 12'd3000, 1'b0);
    push(14'd5, 12'd2519, 1'b0, 1'b0);
    do_trig(1'b0);

    // write and trigger together in IDLE: nothing applied yet
    do_cfg(14'd77, 12'd1234, 1'b1);
    check("coinc_busy", int'(cfg_busy), 1);
    tick();
    push(14'd77, 12'd1234, 1'b0, 1'b0);
    do_trig(1'b0);

    // phase back to 0, then sweep step=1000 count=4 dwell=1
    do_cfg(14'd77, 12'd0, 1'b0);
    push(14'd77, 12'd0, 1'b0, 1'b0);
    do_trig(1'b0);
    do_sweep(12'd1000, 12'd4, 16'd1);
    check("sweep_active_on", int'(sweep_active), 1);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) push(14'd77, sweep_exp[k/2], 1'b1, (k == 7));
      do_trig(1'b0);
      tick();
    end
    check("sweep_active_off", int'(sweep_active), 0);
    check("sweep_phase", int'(phase), 1480);

    // count=0 sweep
    push(14'd77, 12'd1480, 1'b0, 1'b1);
    do_sweep(12'd5, 12'd0, 16'd0);
    check("zero_active", int'(sweep_active), 0);
    tick();
    check("zero_active2", int'(sweep_active), 0);

    // abort after two steps with a coincident trigger
    do_cfg(14'd77, 12'd0, 1'b0);
    push(14'd77, 12'd0, 1'b0, 1'b0);
    do_trig(1'b0);
    do_sweep(12'd1000, 12'd4, 16'd0);
    push(14'd77, 12'd1000, 1'b1, 1'b0);
    do_trig(1'b0);
    push(14'd77, 12'd2000, 1'b1, 1'b0);
    do_trig(1'b0);
    do_trig(1'b1);
    check("abort_active", int'(sweep_active), 0);
    check("abort_phase", int'(phase), 2000);
    tick();

    // abort while pending discards the write
    do_cfg(14'd11, 12'd11, 1'b0);
    sweep_abort = 1'b1;
    tick();
    sweep_abort = 1'b0;
    check("pend_abort_busy", int'(cfg_busy), 0);
    do_trig(1'b0);
    check("pend_abort_hp", int'(hp), 77);

    // latest write wins, applied with a trigger while pending
    do_cfg(14'd1, 12'd1, 1'b0);
    push(14'd2, 12'd2, 1'b0, 1'b0);
    do_cfg(14'd2, 12'd2, 1'b1);
    check("overwrite_busy", int'(cfg_busy), 0);

    // reset mid-sweep
    do_sweep(12'd7, 12'd3, 16'd2);
    do_trig(1'b0);
    push(14'd0, 12'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_active", int'(sweep_active), 0);
    check("midrst_busy", int'(cfg_busy), 0);
    check("midrst_hp", int'(hp), 0);
    rst = 1'b0;
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
